// File: rtl/pong_motion_engine.sv
// Game-state engine feeding the VGA renderer: debounced paddle buttons plus a
// frame-stepped ball with wall bounces, paddle hits and misses.
module pong_motion_engine #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BALL_SIZE       = 10,
  parameter int BALL_SPEED      = 2,
  parameter int LEFT_X          = 55,
  parameter int RIGHT_X         = 600,
  parameter int FIELD_TOP       = 0,
  parameter int FIELD_BOTTOM    = 480,
  parameter int SERVE_X         = 320,
  parameter int SERVE_Y         = 240,
  parameter int PADDLE_Y        = 100,
  parameter int PADDLE_H        = 100,
  parameter int PADDLE_W        = 10,
  parameter int PADDLE_STEP     = 10,
  parameter int PADDLE_MIN      = 60,
  parameter int PADDLE_MAX      = 300,
  parameter int MISS_FRAMES     = 60
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       vsync,
  input  logic       inp1,
  input  logic       inp2,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic [9:0] paddle_x,
  output logic [7:0] score,
  output logic       miss_pulse,
  output logic [1:0] game_state
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int MC_W  = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MC_W-1:0]  MISS_LAST = MC_W'(MISS_FRAMES - 1);

  localparam logic [10:0] SPD        = 11'(BALL_SPEED);
  localparam logic [10:0] BSZ        = 11'(BALL_SIZE);
  localparam logic [10:0] Y_BOT      = 11'(FIELD_BOTTOM - BALL_SIZE);
  localparam logic [10:0] Y_TOP      = 11'(FIELD_TOP);
  localparam logic [10:0] Y_TOP_LIM  = 11'(FIELD_TOP + BALL_SPEED);
  localparam logic [10:0] X_RIGHT    = 11'(RIGHT_X - BALL_SIZE);
  localparam logic [10:0] X_LEFT     = 11'(LEFT_X);
  localparam logic [10:0] X_LEFT_LIM = 11'(LEFT_X + BALL_SPEED);
  localparam logic [10:0] PAD_TOP    = 11'(PADDLE_Y);
  localparam logic [10:0] PAD_BOT    = 11'(PADDLE_Y + PADDLE_H);
  localparam logic [10:0] PAD_W      = 11'(PADDLE_W);
  localparam logic [10:0] P_STEP     = 11'(PADDLE_STEP);
  localparam logic [10:0] P_MIN      = 11'(PADDLE_MIN);
  localparam logic [10:0] P_MAX      = 11'(PADDLE_MAX);
  localparam logic [10:0] P_DN_LIM   = 11'(PADDLE_MIN + PADDLE_STEP);
  localparam logic [9:0]  SX         = 10'(SERVE_X);
  localparam logic [9:0]  SY         = 10'(SERVE_Y);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_MISS = 2'd2} state_t;

  logic [2:0]       vs_q;
  logic [1:0]       b1_q, b2_q;
  logic [1:0]       lvl_q, lvl_prev_q;
  logic [CNT_W-1:0] cnt_q [2];
  logic [1:0]       btn_s, press;
  logic             frame_tick;

  state_t           state_q;
  logic [9:0]       ball_x_q, ball_y_q, paddle_q;
  logic             dx_q, dy_q;
  logic [7:0]       score_q;
  logic             miss_q;
  logic [MC_W-1:0]  mcnt_q;

  logic [9:0]       x_d, y_d, px_d;
  logic             dx_d, dy_d;
  logic [10:0]      bx, by, pad_edge, p_up;
  logic             hit, miss;

  assign btn_s      = {b2_q[1], b1_q[1]};
  assign press      = lvl_q & ~lvl_prev_q;
  // vs_q[2] is the previous synchronised vsync, so this fires once per falling edge
  assign frame_tick = vs_q[2] & ~vs_q[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_q       <= 3'b111;
      b1_q       <= '0;
      b2_q       <= '0;
      lvl_q      <= '0;
      lvl_prev_q <= '0;
      cnt_q[0]   <= '0;
      cnt_q[1]   <= '0;
    end else begin
      vs_q       <= {vs_q[1:0], vsync};
      b1_q       <= {b1_q[0], inp1};
      b2_q       <= {b2_q[0], inp2};
      lvl_prev_q <= lvl_q;
      for (int i = 0; i < 2; i++) begin
        if (btn_s[i] != lvl_q[i]) begin
          if (cnt_q[i] == DEB_LAST) begin
            lvl_q[i] <= btn_s[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_W'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    p_up = {1'b0, paddle_q} + P_STEP;
    px_d = paddle_q;
    if (press[0] && !press[1]) begin
      px_d = (p_up > P_MAX) ? 10'(P_MAX) : p_up[9:0];
    end else if (press[1] && !press[0]) begin
      px_d = ({1'b0, paddle_q} < P_DN_LIM) ? 10'(P_MIN) : 10'({1'b0, paddle_q} - P_STEP);
    end
  end

  // All ball tests run on pre-update position and pre-move paddle
  always_comb begin
    bx       = {1'b0, ball_x_q};
    by       = {1'b0, ball_y_q};
    pad_edge = {1'b0, paddle_q} + PAD_W;
    y_d      = ball_y_q;
    dy_d     = dy_q;
    if (dy_q) begin
      if (by + SPD >= Y_BOT) begin
        y_d  = 10'(Y_BOT);
        dy_d = 1'b0;
      end else begin
        y_d = 10'(by + SPD);
      end
    end else if (by < Y_TOP_LIM) begin
      y_d  = 10'(Y_TOP);
      dy_d = 1'b1;
    end else begin
      y_d = 10'(by - SPD);
    end

    hit  = !dx_q && (by + BSZ > PAD_TOP) && (by < PAD_BOT) &&
           (bx >= pad_edge) && (bx - SPD <= pad_edge);
    miss = !dx_q && !hit && (bx < X_LEFT_LIM);
    x_d  = ball_x_q;
    dx_d = dx_q;
    if (dx_q) begin
      if (bx + SPD >= X_RIGHT) begin
        x_d  = 10'(X_RIGHT);
        dx_d = 1'b0;
      end else begin
        x_d = 10'(bx + SPD);
      end
    end else if (hit) begin
      x_d  = 10'(pad_edge);
      dx_d = 1'b1;
    end else if (miss) begin
      x_d = 10'(X_LEFT);
    end else begin
      x_d = 10'(bx - SPD);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_SERVE;
      ball_x_q <= SX;
      ball_y_q <= SY;
      dx_q     <= 1'b0;
      dy_q     <= 1'b1;
      paddle_q <= 10'(P_MIN);
      score_q  <= '0;
      miss_q   <= 1'b0;
      mcnt_q   <= '0;
    end else begin
      miss_q   <= 1'b0;
      paddle_q <= px_d;
      case (state_q)
        S_SERVE: begin
          if (|press) begin
            state_q <= S_PLAY;
            dx_q    <= 1'b0;
            dy_q    <= 1'b1;
          end
        end
        S_PLAY: begin
          if (frame_tick) begin
            ball_x_q <= x_d;
            ball_y_q <= y_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            if (hit && score_q != 8'hFF) score_q <= score_q + 8'd1;
            if (miss) begin
              state_q <= S_MISS;
              miss_q  <= 1'b1;
              mcnt_q  <= '0;
            end
          end
        end
        S_MISS: begin
          if (frame_tick) begin
            if (mcnt_q == MISS_LAST) begin
              state_q  <= S_SERVE;
              ball_x_q <= SX;
              ball_y_q <= SY;
              mcnt_q   <= '0;
            end else begin
              mcnt_q <= mcnt_q + MC_W'(1);
            end
          end
        end
        default: state_q <= S_SERVE;
      endcase
    end
  end

  assign ball_x     = ball_x_q;
  assign ball_y     = ball_y_q;
  assign paddle_x   = paddle_q;
  assign score      = score_q;
  assign miss_pulse = miss_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_pong_motion_engine.sv
// Scoreboard bench for pong_motion_engine: directed button/vsync stimulus with
// hand-computed ball trajectory checkpoints (paddle lowered to y=400 so it can be reached).
module tb_pong_motion_engine;

  localparam int DEB = 4;

  logic       clock = 1'b0;
  logic       reset_n, vsync, inp1, inp2;
  logic [9:0] ball_x, ball_y, paddle_x;
  logic [7:0] score;
  logic       miss_pulse;
  logic [1:0] game_state;

  always #5 clock = ~clock;

  pong_motion_engine #(.DEBOUNCE_CYCLES(DEB), .PADDLE_Y(400)) dut (
    .clock(clock), .reset_n(reset_n), .vsync(vsync), .inp1(inp1), .inp2(inp2),
    .ball_x(ball_x), .ball_y(ball_y), .paddle_x(paddle_x), .score(score),
    .miss_pulse(miss_pulse), .game_state(game_state)
  );

  typedef struct {
    string name;
    int bx; int by; int px; int sc; int st; int ms;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  int miss_seen = 0;

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  task automatic sb_push(input string nm, input int bx, input int by, input int px,
                         input int sc, input int st, input int ms);
    exp_t e;
    e.name = nm; e.bx = bx; e.by = by; e.px = px; e.sc = sc; e.st = st; e.ms = ms;
    exp_q.push_back(e);
  endtask

  // Monitor: tallies miss pulses and drains pending expectations on the quiet edge
  always @(negedge clock) begin
    exp_t e;
    if (miss_pulse) miss_seen++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({e.name, ".ball_x"},   int'(ball_x),     e.bx);
      chk({e.name, ".ball_y"},   int'(ball_y),     e.by);
      chk({e.name, ".paddle_x"}, int'(paddle_x),   e.px);
      chk({e.name, ".score"},    int'(score),      e.sc);
      chk({e.name, ".state"},    int'(game_state), e.st);
      chk({e.name, ".misses"},   miss_seen,        e.ms);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0;
      repeat (4) step();
      vsync = 1'b1;
      repeat (4) step();
    end
  endtask

  task automatic press(input logic b1, input logic b2, input int hold);
    inp1 = b1;
    inp2 = b2;
    repeat (hold) step();
    inp1 = 1'b0;
    inp2 = 1'b0;
    repeat (10) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0; vsync = 1'b1; inp1 = 1'b0; inp2 = 1'b0;
    repeat (3) step();
    sb_push("in_reset", 320, 240, 60, 0, 0, 0);
    reset_n = 1'b1;
    repeat (2) step();
    sb_push("after_reset", 320, 240, 60, 0, 0, 0);

    ticks(5);
    sb_push("serve_hold", 320, 240, 60, 0, 0, 0);
    press(1'b1, 1'b0, 3);
    sb_push("short_glitch", 320, 240, 60, 0, 0, 0);
    press(1'b1, 1'b0, 10);
    sb_push("first_press", 320, 240, 70, 0, 1, 0);
    repeat (29) press(1'b1, 1'b0, 10);
    sb_push("paddle_max", 320, 240, 300, 0, 1, 0);
    press(1'b1, 1'b1, 10);
    sb_push("both_pressed", 320, 240, 300, 0, 1, 0);
    repeat (25) press(1'b0, 1'b1, 10);
    sb_push("paddle_min", 320, 240, 60, 0, 1, 0);

    // First rally: down-left diagonal, bottom bounce, then paddle hit at x=72
    ticks(114);
    sb_push("y468_down", 92, 468, 60, 0, 1, 0);
    ticks(1);
    sb_push("bottom_clamp", 90, 470, 60, 0, 1, 0);
    ticks(1);
    sb_push("bottom_bounce", 88, 468, 60, 0, 1, 0);
    ticks(8);
    sb_push("pre_hit", 72, 452, 60, 0, 1, 0);
    ticks(1);
    sb_push("paddle_hit", 70, 450, 60, 1, 1, 0);
    ticks(1);
    sb_push("rebound", 72, 448, 60, 1, 1, 0);
    ticks(225);
    sb_push("top_clamp", 522, 0, 60, 1, 1, 0);
    ticks(1);
    sb_push("top_bounce", 524, 2, 60, 1, 1, 0);
    ticks(33);
    sb_push("right_clamp", 590, 68, 60, 1, 1, 0);
    ticks(1);
    sb_push("right_bounce", 588, 70, 60, 1, 1, 0);

    // Second approach arrives above the paddle and goes on to the goal line
    ticks(259);
    sb_push("pass_paddle", 70, 352, 60, 1, 1, 0);
    ticks(7);
    sb_push("pre_miss", 56, 338, 60, 1, 1, 0);
    ticks(1);
    sb_push("miss", 55, 336, 60, 1, 2, 1);
    ticks(59);
    sb_push("miss_hold59", 55, 336, 60, 1, 2, 1);
    ticks(1);
    sb_push("reserve", 320, 240, 60, 1, 0, 1);

    press(1'b0, 1'b1, 10);
    sb_push("serve_inp2", 320, 240, 60, 1, 1, 1);
    ticks(3);
    sb_push("replay", 314, 246, 60, 1, 1, 1);

    step();
    reset_n = 1'b0;
    #1;
    chk("async.ball_x",     int'(ball_x),     320);
    chk("async.ball_y",     int'(ball_y),     240);
    chk("async.paddle_x",   int'(paddle_x),   60);
    chk("async.score",      int'(score),      0);
    chk("async.state",      int'(game_state), 0);
    chk("async.miss_pulse", int'(miss_pulse), 0);
    step();
    sb_push("reset_held", 320, 240, 60, 0, 0, 1);
    step();
    reset_n = 1'b1;
    ticks(2);
    sb_push("post_reset_serve", 320, 240, 60, 0, 0, 1);

    begin
      int w;
      w = 0;
      while (exp_q.size() > 0 && w < 20) begin
        step();
        w++;
      end
      if (exp_q.size() > 0) chk("scoreboard_drain", exp_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
